// File: rtl/vga_frame_buffer_if.sv
// Write port of the VGA frame buffer.
//   wr_valid / wr_ready : handshake, a write is taken when both are high
//   wr_x, wr_y          : buffer column / row of the pixel
//   wr_data             : pixel colour, RRRGGGBB
// master = drawing logic, slave = frame buffer.
interface vga_frame_buffer_if;
    logic       wr_valid;
    logic       wr_ready;
    logic [7:0] wr_x;
    logic [6:0] wr_y;
    logic [7:0] wr_data;

    modport master (output wr_valid, wr_x, wr_y, wr_data, input wr_ready);
    modport slave  (input wr_valid, wr_x, wr_y, wr_data, output wr_ready);
endinterface

// File: rtl/vga_frame_buffer.sv
// Frame buffer feeding the VGA output. It holds a low-resolution image in
// which each pixel covers a (1<<SCALE_LOG2)-square block of the raster. The
// sync generator's counters drive a 3-stage read pipeline that produces
// 8-bit R/G/B with H_SYNC/V_SYNC delayed to match. A write port lets the
// drawing logic update single pixels. A clear engine fills the whole
// buffer with CLEAR_COLOR.
//
// Ports:
//   clk, rst_n             pixel clock, async active-low reset
//   h_counter, v_counter   raster position from the sync generator
//   v_en                   active-video flag
//   h_sync_in, v_sync_in   raw syncs (active-low)
//   wr                     write port (vga_frame_buffer_if.slave)
//   wr_err                 sticky: an accepted write was out of range
//   clear_req, clear_busy  clear request pulse / clear in progress
//   r, g, b                expanded pixel colour
//   h_sync, v_sync         syncs aligned with r/g/b
//
// Macro VGA_FB_VBLANK_CLEAR_EN: when defined, a requested clear waits for
// vertical blanking so no torn frame is shown. When undefined, the clear
// starts one cycle after the request.
module vga_frame_buffer #(
    parameter int         H_ACTIVE    = 640,
    parameter int         V_ACTIVE    = 480,
    parameter int         SCALE_LOG2  = 2,
    parameter logic [7:0] CLEAR_COLOR = 8'h00
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [9:0]           h_counter,
    input  logic [9:0]           v_counter,
    input  logic                 v_en,
    input  logic                 h_sync_in,
    input  logic                 v_sync_in,
    vga_frame_buffer_if.slave    wr,
    output logic                 wr_err,
    input  logic                 clear_req,
    output logic                 clear_busy,
    output logic [7:0]           r,
    output logic [7:0]           g,
    output logic [7:0]           b,
    output logic                 h_sync,
    output logic                 v_sync
);
    localparam int FB_W  = H_ACTIVE >> SCALE_LOG2;
    localparam int FB_H  = V_ACTIVE >> SCALE_LOG2;
    localparam int DEPTH = FB_W * FB_H;
    localparam int AW    = $clog2(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_WAIT_VB, S_CLEAR} state_t;

    state_t         state, state_nx;
    logic [AW-1:0]  clr_addr;
    logic [7:0]     mem [DEPTH];
    logic [7:0]     rd_data;
    logic [AW-1:0]  rd_addr, rd_addr_c;
    logic           act_c;
    logic [1:0]     vld_pipe;
    logic [2:0]     hs_pipe, vs_pipe;
    logic [9:0]     bx, by;
    logic           wr_fire, wr_in_range;
    logic [AW-1:0]  wr_addr_c;
    logic           mem_we;
    logic [AW-1:0]  mem_waddr;
    logic [7:0]     mem_wdata;

    // ---------------- read pipeline ----------------
    assign bx    = h_counter >> SCALE_LOG2;
    assign by    = v_counter >> SCALE_LOG2;
    assign act_c = v_en && (32'(h_counter) < H_ACTIVE) && (32'(v_counter) < V_ACTIVE);
    // Blanked positions read address 0 so the RAM index always stays in range.
    assign rd_addr_c = act_c ? AW'(32'(by) * FB_W + 32'(bx)) : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_addr  <= '0;
            vld_pipe <= '0;
            hs_pipe  <= '1;
            vs_pipe  <= '1;
            r        <= '0;
            g        <= '0;
            b        <= '0;
        end else begin
            rd_addr  <= rd_addr_c;
            vld_pipe <= {vld_pipe[0], act_c};
            hs_pipe  <= {hs_pipe[1:0], h_sync_in};
            vs_pipe  <= {vs_pipe[1:0], v_sync_in};
            // Channel bits are replicated so that full scale maps to 8'hFF.
            if (vld_pipe[1]) begin
                r <= {rd_data[7:5], rd_data[7:5], rd_data[7:6]};
                g <= {rd_data[4:2], rd_data[4:2], rd_data[4:3]};
                b <= {4{rd_data[1:0]}};
            end else begin
                r <= '0;
                g <= '0;
                b <= '0;
            end
        end
    end

    assign h_sync = hs_pipe[2];
    assign v_sync = vs_pipe[2];

`ifdef VGA_FB_VBLANK_CLEAR_EN
    // V_EN delayed to line up with the displayed pixel.
    logic [2:0] ven_pipe;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ven_pipe <= '0;
        else        ven_pipe <= {ven_pipe[1:0], v_en};
    end
`endif

    // ---------------- RAM (read-first, not reset) ----------------
    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_waddr] <= mem_wdata;
        rd_data <= mem[rd_addr];
    end

    // ---------------- write port and clear FSM ----------------
    assign wr_fire     = wr.wr_valid && wr.wr_ready;
    assign wr_in_range = (32'(wr.wr_x) < FB_W) && (32'(wr.wr_y) < FB_H);
    assign wr_addr_c   = AW'(32'(wr.wr_y) * FB_W + 32'(wr.wr_x));
    assign clear_busy  = (state != S_IDLE);

    always_comb begin
        state_nx  = state;
        mem_we    = wr_fire && wr_in_range;
        mem_waddr = wr_addr_c;
        mem_wdata = wr.wr_data;
        case (state)
            S_IDLE:    if (clear_req) state_nx = S_WAIT_VB;
            S_WAIT_VB: begin
`ifdef VGA_FB_VBLANK_CLEAR_EN
                if (!ven_pipe[2] && (32'(v_counter) >= V_ACTIVE)) state_nx = S_CLEAR;
`else
                state_nx = S_CLEAR;
`endif
            end
            S_CLEAR: begin
                // wr_ready is low here, so the clear owns the write port.
                mem_we    = 1'b1;
                mem_waddr = clr_addr;
                mem_wdata = CLEAR_COLOR;
                if (clr_addr == AW'(DEPTH - 1)) state_nx = S_IDLE;
            end
            default:   state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            clr_addr    <= '0;
            wr.wr_ready <= 1'b0;
            wr_err      <= 1'b0;
        end else begin
            state       <= state_nx;
            // Registered ready tracks the state being entered.
            wr.wr_ready <= (state_nx == S_IDLE);
            if (wr_fire && !wr_in_range) wr_err <= 1'b1;
            clr_addr    <= (state == S_CLEAR) ? clr_addr + 1'b1 : '0;
        end
    end
endmodule
